// File: rtl/alu_decode_stage_if.sv
// Fetch/writeback/execute signal bundle for alu_decode_stage.
// The slave modport is the decode stage; the master modport is whatever surrounds it.
interface alu_decode_stage_if;
  logic [31:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [31:0] imm;
  logic [6:0]  control_out;
  logic [4:0]  dest_addr;
  logic        enable_ex;

  modport slave (
    input  instr_in, instr_valid, wb_en, wb_addr, wb_data,
    output instr_ready, src1, src2, imm, control_out, dest_addr, enable_ex
  );

  modport master (
    output instr_in, instr_valid, wb_en, wb_addr, wb_data,
    input  instr_ready, src1, src2, imm, control_out, dest_addr, enable_ex
  );
endinterface

// File: rtl/alu_decode_stage.sv
// Decode/operand-fetch stage feeding the ALU execute pipeline, with load-use bubble insertion.
// Optional macro DECODE_WB_BYPASS_EN forwards same-cycle writeback data into src1/src2.
module alu_decode_stage #(
  parameter int         NUM_REGS   = 32,
  parameter logic [2:0] LOAD_OPSEL = 3'b101
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic               enable_decode,
  alu_decode_stage_if.slave  bus
);
  typedef enum logic {RUN = 1'b0, BUBBLE = 1'b1} state_t;

  state_t      state_reg;
  logic [31:0] regs [NUM_REGS];

  logic [31:0] src1_reg, src2_reg, imm_reg;
  logic [6:0]  control_reg;
  logic [4:0]  dest_reg;
  logic        enable_ex_reg;
  logic        prev_load_reg;
  logic [4:0]  prev_rd_reg;

  logic [2:0]  opselect, operation;
  logic        imm_sel;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_next, rs1_data, rs2_data;
  logic        hazard;

  assign opselect  = bus.instr_in[31:29];
  assign operation = bus.instr_in[28:26];
  assign imm_sel   = bus.instr_in[25];
  assign rd        = bus.instr_in[24:20];
  assign rs1       = bus.instr_in[19:15];
  assign rs2       = bus.instr_in[14:10];
  assign imm_next  = {{17{bus.instr_in[14]}}, bus.instr_in[14:0]};

  // rs2 only counts as a source when the immediate is not selected.
  assign hazard = (state_reg == RUN) && prev_load_reg && (prev_rd_reg != 5'd0) &&
                  bus.instr_valid &&
                  ((rs1 == prev_rd_reg) || (!imm_sel && (rs2 == prev_rd_reg)));

  assign bus.instr_ready = enable_decode & ~RESET & ~hazard;

  always_comb begin
    rs1_data = (rs1 == 5'd0) ? 32'd0 : regs[rs1];
    rs2_data = (rs2 == 5'd0) ? 32'd0 : regs[rs2];
`ifdef DECODE_WB_BYPASS_EN
    if (bus.wb_en && (bus.wb_addr != 5'd0) && (bus.wb_addr == rs1)) rs1_data = bus.wb_data;
    if (bus.wb_en && (bus.wb_addr != 5'd0) && (bus.wb_addr == rs2)) rs2_data = bus.wb_data;
`endif
  end

  // Register file is deliberately left out of reset; writeback runs even while frozen.
  always_ff @(posedge CLOCK) begin
    if (bus.wb_en && (bus.wb_addr != 5'd0)) regs[bus.wb_addr] <= bus.wb_data;
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_reg     <= RUN;
      src1_reg      <= '0;
      src2_reg      <= '0;
      imm_reg       <= '0;
      control_reg   <= '0;
      dest_reg      <= '0;
      enable_ex_reg <= 1'b0;
      prev_load_reg <= 1'b0;
      prev_rd_reg   <= '0;
    end else if (enable_decode) begin
      state_reg <= hazard ? BUBBLE : RUN;
      if (hazard) begin
        // Instruction stays on the bus; clearing the tracker lets it issue next cycle.
        enable_ex_reg <= 1'b0;
        control_reg   <= '0;
        prev_load_reg <= 1'b0;
        prev_rd_reg   <= '0;
      end else if (bus.instr_valid) begin
        src1_reg      <= rs1_data;
        src2_reg      <= rs2_data;
        imm_reg       <= imm_next;
        control_reg   <= {opselect, imm_sel, operation};
        dest_reg      <= rd;
        enable_ex_reg <= 1'b1;
        prev_load_reg <= (opselect == LOAD_OPSEL);
        prev_rd_reg   <= rd;
      end else begin
        enable_ex_reg <= 1'b0;
        prev_load_reg <= 1'b0;
        prev_rd_reg   <= '0;
      end
    end
  end

  assign bus.src1        = src1_reg;
  assign bus.src2        = src2_reg;
  assign bus.imm         = imm_reg;
  assign bus.control_out = control_reg;
  assign bus.dest_addr   = dest_reg;
  assign bus.enable_ex   = enable_ex_reg;
endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: expected execute outputs are queued when an
// instruction is driven and compared when the stage presents it.
module tb_alu_decode_stage;
  logic CLOCK;
  logic RESET;
  logic enable_decode;

  alu_decode_stage_if bus ();

  alu_decode_stage dut (
    .CLOCK         (CLOCK),
    .RESET         (RESET),
    .enable_decode (enable_decode),
    .bus           (bus)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] imm;
    logic [6:0]  ctrl;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb [$];
  exp_t        cur;
  exp_t        e;
  logic [31:0] rf_m [32];
  int          total  = 0;
  int          passed = 0;
  int          failed = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [2:0] op, input logic [2:0] oper,
                                     input logic isel, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [9:0] lo);
    return {op, oper, isel, rd, rs1, rs2, lo};
  endfunction

  function automatic exp_t expect_of(input logic [31:0] ins);
    exp_t r;
    r.src1 = (ins[19:15] == 5'd0) ? 32'd0 : rf_m[ins[19:15]];
    r.src2 = (ins[14:10] == 5'd0) ? 32'd0 : rf_m[ins[14:10]];
    r.imm  = {{17{ins[14]}}, ins[14:0]};
    r.ctrl = {ins[31:29], ins[25], ins[28:26]};
    r.rd   = ins[24:20];
    return r;
  endfunction

  // Check ready before the edge, then all execute-side outputs after it.
  task automatic tick(input string tag, input logic exp_rdy, input logic exp_ex,
                      input logic do_pop, input logic bubble);
    #1;
    chk({tag, ".ready"}, {31'd0, bus.instr_ready}, {31'd0, exp_rdy});
    @(posedge CLOCK);
    #1;
    if (do_pop) begin
      total++;
      assert (sb.size() != 0) passed++;
      else begin
        failed++;
        $error("FAIL %s.scoreboard: got 0 entries expected 1", tag);
      end
      if (sb.size() != 0) cur = sb.pop_front();
    end
    if (bubble) cur.ctrl = '0;
    chk({tag, ".enable_ex"}, {31'd0, bus.enable_ex}, {31'd0, exp_ex});
    chk({tag, ".src1"}, bus.src1, cur.src1);
    chk({tag, ".src2"}, bus.src2, cur.src2);
    chk({tag, ".imm"}, bus.imm, cur.imm);
    chk({tag, ".control"}, {25'd0, bus.control_out}, {25'd0, cur.ctrl});
    chk({tag, ".dest"}, {27'd0, bus.dest_addr}, {27'd0, cur.rd});
  endtask

  task automatic issue(input logic [31:0] ins);
    bus.instr_valid = 1'b1;
    bus.instr_in    = ins;
    sb.push_back(expect_of(ins));
  endtask

  task automatic idle();
    bus.instr_valid = 1'b0;
    bus.instr_in    = 32'd0;
  endtask

  task automatic wb_write(input logic [4:0] addr, input logic [31:0] data);
    idle();
    bus.wb_en   = 1'b1;
    bus.wb_addr = addr;
    bus.wb_data = data;
    tick("wb", 1'b1, 1'b0, 1'b0, 1'b0);
    if (addr != 5'd0) rf_m[addr] = data;
    bus.wb_en = 1'b0;
  endtask

  logic [31:0] ins_d;

  initial begin
    for (int i = 0; i < 32; i++) rf_m[i] = 32'd0;
    cur           = '0;
    RESET         = 1'b1;
    enable_decode = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr_in    = 32'd0;
    bus.wb_en       = 1'b0;
    bus.wb_addr     = 5'd0;
    bus.wb_data     = 32'd0;

    // Reset held two cycles: everything zero, not ready.
    tick("reset0", 1'b0, 1'b0, 1'b0, 1'b0);
    tick("reset1", 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge CLOCK);
    RESET = 1'b0;

    // Give every register a known value, then the two from the basic test.
    for (int i = 1; i < 32; i++) wb_write(5'(i), (32'h0101_0101 * i) ^ 32'hA5A5_0000);
    wb_write(5'd3, 32'h0000_1234);
    wb_write(5'd4, 32'hFFFF_0001);

    // Basic issue.
    issue(mk(3'b011, 3'b001, 1'b0, 5'd5, 5'd3, 5'd4, 10'd0));
    tick("basic", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("basic.src1_const", bus.src1, 32'h0000_1234);
    chk("basic.src2_const", bus.src2, 32'hFFFF_0001);
    chk("basic.ctrl_const", {25'd0, bus.control_out}, {25'd0, 7'b011_0_001});

    idle();
    tick("novalid", 1'b1, 1'b0, 1'b0, 1'b0);

    // Immediate path: instr[14:0] = 15'h4000.
    issue(mk(3'b000, 3'b010, 1'b1, 5'd6, 5'd3, 5'd16, 10'd0));
    tick("imm", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("imm.const", bus.imm, 32'hFFFF_C000);

    // Load-use on rs1: one bubble, then the dependent instruction issues.
    issue(mk(3'b101, 3'b000, 1'b1, 5'd7, 5'd3, 5'd1, 10'd4));
    tick("load7", 1'b1, 1'b1, 1'b1, 1'b0);
    issue(mk(3'b011, 3'b001, 1'b0, 5'd8, 5'd7, 5'd4, 10'd0));
    tick("haz_rs1", 1'b0, 1'b0, 1'b0, 1'b1);
    tick("haz_rs1_issue", 1'b1, 1'b1, 1'b1, 1'b0);

    // Load to r0 never stalls.
    issue(mk(3'b101, 3'b000, 1'b1, 5'd0, 5'd3, 5'd1, 10'd0));
    tick("load0", 1'b1, 1'b1, 1'b1, 1'b0);
    issue(mk(3'b011, 3'b001, 1'b0, 5'd8, 5'd0, 5'd0, 10'd0));
    tick("nohaz_r0", 1'b1, 1'b1, 1'b1, 1'b0);

    // rs2 ignored when imm_sel=1.
    issue(mk(3'b101, 3'b000, 1'b1, 5'd10, 5'd3, 5'd1, 10'd0));
    tick("load10", 1'b1, 1'b1, 1'b1, 1'b0);
    issue(mk(3'b010, 3'b011, 1'b1, 5'd12, 5'd2, 5'd10, 10'd9));
    tick("nohaz_imm", 1'b1, 1'b1, 1'b1, 1'b0);

    // rs2 counts when imm_sel=0.
    issue(mk(3'b101, 3'b000, 1'b1, 5'd11, 5'd3, 5'd1, 10'd0));
    tick("load11", 1'b1, 1'b1, 1'b1, 1'b0);
    issue(mk(3'b001, 3'b100, 1'b0, 5'd13, 5'd2, 5'd11, 10'd0));
    tick("haz_rs2", 1'b0, 1'b0, 1'b0, 1'b1);
    tick("haz_rs2_issue", 1'b1, 1'b1, 1'b1, 1'b0);

    // Freeze three cycles mid-stream.
    issue(mk(3'b100, 3'b110, 1'b0, 5'd14, 5'd20, 5'd21, 10'd0));
    tick("pre_freeze", 1'b1, 1'b1, 1'b1, 1'b0);
    issue(mk(3'b110, 3'b111, 1'b0, 5'd15, 5'd22, 5'd23, 10'd0));
    enable_decode = 1'b0;
    for (int i = 0; i < 3; i++) tick("freeze", 1'b0, 1'b1, 1'b0, 1'b0);
    enable_decode = 1'b1;
    tick("resume", 1'b1, 1'b1, 1'b1, 1'b0);
    idle();
    tick("post_resume", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("post_resume.sb_empty", sb.size(), 32'd0);

    // Same-cycle writeback and read of r9.
    bus.wb_en   = 1'b1;
    bus.wb_addr = 5'd9;
    bus.wb_data = 32'hDEAD_BEEF;
    bus.instr_valid = 1'b1;
    bus.instr_in    = mk(3'b011, 3'b000, 1'b0, 5'd16, 5'd9, 5'd2, 10'd0);
    e = expect_of(bus.instr_in);
`ifdef DECODE_WB_BYPASS_EN
    e.src1 = 32'hDEAD_BEEF;
`endif
    sb.push_back(e);
    tick("wb_same", 1'b1, 1'b1, 1'b1, 1'b0);
    rf_m[9]   = 32'hDEAD_BEEF;
    bus.wb_en = 1'b0;
    issue(mk(3'b011, 3'b000, 1'b0, 5'd16, 5'd9, 5'd2, 10'd0));
    tick("wb_after", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("wb_after.const", bus.src1, 32'hDEAD_BEEF);

    // Writes to r0 are discarded.
    wb_write(5'd0, 32'h5555_AAAA);
    issue(mk(3'b000, 3'b001, 1'b0, 5'd1, 5'd0, 5'd0, 10'd0));
    tick("r0_read", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("r0.src1", bus.src1, 32'd0);
    chk("r0.src2", bus.src2, 32'd0);

    // Reset during BUBBLE drops the held instruction; it must be re-presented.
    issue(mk(3'b101, 3'b000, 1'b1, 5'd12, 5'd3, 5'd1, 10'd0));
    tick("load12", 1'b1, 1'b1, 1'b1, 1'b0);
    ins_d = mk(3'b011, 3'b010, 1'b0, 5'd17, 5'd12, 5'd5, 10'd0);
    issue(ins_d);
    tick("haz_pre_rst", 1'b0, 1'b0, 1'b0, 1'b1);
    RESET = 1'b1;
    void'(sb.pop_back());
    cur = '0;
    tick("rst_bubble", 1'b0, 1'b0, 1'b0, 1'b0);
    RESET = 1'b0;
    issue(ins_d);
    tick("reissue", 1'b1, 1'b1, 1'b1, 1'b0);
    chk("end.sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/alu_decode_stage.md
Name: alu_decode_stage

Overview:
- Decode/operand-fetch stage directly upstream of the ALU execute pipeline.
- Accepts 32-bit instructions from fetch on a valid/ready handshake and decodes them.
- Reads operands from an internal 32x32 register file, which has a write port driven by writeback.
- Drives the execute-stage inputs: src1, src2, imm, control, enable_ex. Inserts a one-cycle bubble on load-use hazards.

Parameters:
- NUM_REGS, 32, register file depth (addresses 5 bits)
- LOAD_OPSEL, 3'b101, opselect code identifying a memory-read instruction

Ports:
- CLOCK  in  1  rising-edge clock
- RESET  in  1  synchronous, active-high reset
- enable_decode  in  1  stage enable; low freezes the stage
- instr_in  in  32  instruction word from fetch
- instr_valid  in  1  instr_in is valid
- instr_ready  out  1  stage accepts instr_in this cycle
- wb_en  in  1  register file write enable
- wb_addr  in  5  register file write address
- wb_data  in  32  register file write data
- src1  out  32  operand 1 to execute
- src2  out  32  operand 2 to execute
- imm  out  32  sign-extended immediate
- control_out  out  7  {opselect[2:0], imm_sel, operation[2:0]} to execute control_in
- dest_addr  out  5  destination register carried to writeback
- enable_ex  out  1  execute-stage valid/enable

Behaviour:
- Instruction fields:
  - [31:29] opselect
  - [28:26] operation
  - [25] imm_sel
  - [24:20] rd
  - [19:15] rs1
  - [14:10] rs2
  - imm = sign-extend of instr[14:0] to 32 bits; imm is always computed.
- Register file:
  - Synchronous write on CLOCK when wb_en=1.
  - Writes to r0 are ignored; r0 always reads 0.
  - The register file is not cleared by RESET.
- Reset values: src1, src2, imm, control_out, dest_addr = 0; enable_ex = 0; instr_ready = 0 in the reset cycle; hazard tracker cleared.
- Latency: one cycle. An instruction accepted at edge N (instr_valid & instr_ready) presents its decoded outputs, with enable_ex=1, after edge N.
- Output registers load only when enable_decode=1.
- instr_ready = enable_decode & ~RESET & ~hazard.
- State machine, two states:
  - RUN: normal issue.
  - BUBBLE: one cycle.
- Hazard: asserted in RUN when all of the following hold:
  - the previously issued instruction had opselect==LOAD_OPSEL;
  - its rd is not 0;
  - current instr_valid=1;
  - current rs1==prev rd, OR (imm_sel==0 AND rs2==prev rd).
- On hazard: go to BUBBLE. The next edge loads enable_ex=0 and control_out=0. The instruction is not consumed. The stage returns to RUN, and the tracker is cleared, so the same instruction then issues.
- No instr_valid in RUN: enable_ex loads 0; other outputs hold; tracker is cleared.
- enable_decode=0: all registers and state hold, including enable_ex. No register-file read side effects. Writeback writes still occur.
- Simultaneous wb_en write and read of the same address: see Optional Feature.
- RESET during BUBBLE returns to RUN. The held instruction is dropped; fetch must re-present it.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN
- Defined: when wb_en=1, wb_addr!=0 and wb_addr matches rs1 (or rs2), the stage captures wb_data into src1 (or src2) in the same cycle.
- Undefined: the stage captures the old register-file contents. Software or fetch must separate the dependent instruction by at least one cycle.

Test Plan:
- Reset check: RESET=1 for 2 cycles -> all outputs 0, enable_ex=0, instr_ready=0. The cycle after release: instr_ready=1 with enable_decode=1.
- Basic issue:
  - Setup: write r3=0x0000_1234 and r4=0xFFFF_0001 via wb.
  - Stimulus: issue opselect=3'b011, operation=3'b001, imm_sel=0, rd=5, rs1=3, rs2=4.
  - Response, next cycle: src1=0x0000_1234, src2=0xFFFF_0001, control_out=7'b011_0_001, dest_addr=5, enable_ex=1.
- Immediate path: instr[14:0]=15'h4000 with imm_sel=1 -> imm=0xFFFF_C000. rs2 is ignored for the hazard check.
- Load-use hazard:
  - Stimulus: load with rd=7, followed by an instruction with rs1=7.
  - Response: instr_ready=0 for one cycle, then one cycle with enable_ex=0, then the dependent instruction issues.
  - Control: the same sequence with rd=0 -> no bubble.
- Freeze: enable_decode=0 for 3 cycles mid-stream -> outputs and enable_ex unchanged, instr_ready=0. Resumes with no lost or duplicated instruction.
- Same-cycle write/read: wb_en=1, wb_addr=9, wb_data=0xDEAD_BEEF, while reading rs1=9 in the same cycle.
  - DECODE_WB_BYPASS_EN defined: src1=0xDEAD_BEEF.
  - Undefined: src1 = old r9 value.
  - In both builds, a write to r0 -> subsequent reads of r0 = 0.
